// File: rtl/alu_seq.sv
// Sequential ALU: latches two operands on a load command, runs a one-hot op,
// with a WIDTH-iteration shift-add unsigned multiplier and exposed FSM status.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [6:0]       out_sel,
  output logic [WIDTH-1:0] final1,
  output logic [WIDTH-1:0] final2,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       currState,
  output logic [1:0]       nextState
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    MULT = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH:0]       res;
  logic                 cmd_rst;
  logic                 cmd_load;
  logic                 op_legal;
  logic                 op_mul;
  logic                 mul_last;
  logic                 bit_sel;

  // Single-cycle ops; bit WIDTH carries the carry/borrow flag.
  function automatic logic [WIDTH:0] single_op(input logic [6:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    logic [32:0]    sh;
    r  = '0;
    sh = 33'(b);
    case (op)
      7'b1000000: r = {1'b0, a} + {1'b0, b};
      7'b0100000: r = {(a < b), a - b};
      7'b0010000: r = {1'b0, a & b};
      7'b0001000: r = {1'b0, a | b};
      7'b0000100: r = {1'b0, a ^ b};
      7'b0000010: begin
        if (sh >= 33'(WIDTH)) r = '0;
        else                  r = {1'b0, a << b};
      end
      default:    r = '0;
    endcase
    return r;
  endfunction

  assign cmd_rst   = (in_sel == 3'b001);
  assign cmd_load  = (in_sel == 3'b010);
  assign op_legal  = (out_sel != 7'd0) && ((out_sel & (out_sel - 7'd1)) == 7'd0);
  assign op_mul    = (out_sel == 7'b0000001);
  assign mul_last  = (cnt == CW'(WIDTH - 1));
  assign bit_sel   = |(final2 & (WIDTH'(1) << cnt));
  assign acc_next  = acc + (bit_sel ? ({{WIDTH{1'b0}}, final1} << cnt) : '0);
  assign res       = single_op(out_sel, final1, final2);
  assign currState = state;
  assign nextState = next_state;

  always_comb begin
    next_state = state;
    if (on) begin
      if (cmd_rst) begin
        next_state = IDLE;
      end else begin
        case (state)
          IDLE: if (cmd_load) next_state = LOAD;
          LOAD: next_state = op_mul ? MULT : DONE;
          MULT: if (mul_last) next_state = DONE;
          DONE: next_state = IDLE;
          default: next_state = IDLE;
        endcase
      end
    end
  end

  // Register stage: operands, results, flags and FSM advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      final1 <= '0;
      final2 <= '0;
      out    <= '0;
      out_hi <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else if (on) begin
      state <= next_state;
      busy  <= (next_state == LOAD) || (next_state == MULT);
      done  <= (next_state == DONE);
      if (cmd_rst) begin
        final1 <= '0;
        final2 <= '0;
        out    <= '0;
        out_hi <= '0;
        carry  <= 1'b0;
        zero   <= 1'b0;
        err    <= 1'b0;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_load) begin
              final1 <= num1;
              final2 <= num2;
              err    <= 1'b0;
            end
          end
          LOAD: begin
            if (op_mul) begin
              acc <= '0;
              cnt <= '0;
            end else if (op_legal) begin
              out    <= res[WIDTH-1:0];
              carry  <= res[WIDTH];
              zero   <= (res[WIDTH-1:0] == '0);
              out_hi <= '0;
            end else begin
              err <= 1'b1;
            end
          end
          MULT: begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (mul_last) begin
              out    <= acc_next[WIDTH-1:0];
              out_hi <= acc_next[2*WIDTH-1:WIDTH];
              carry  <= |acc_next[2*WIDTH-1:WIDTH];
              zero   <= (acc_next == '0);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the 8-bit `main` ALU.
- Latches two WIDTH-bit operands on a load command and executes the one-hot operation on out_sel.
- Single-cycle ops: add, sub, and, or, xor, shl. Multi-cycle op: shift-add unsigned multiply.
- Exposes FSM state, busy/done/error status and carry/zero flags to the top level and the bench.

Parameters:
- WIDTH, 8, operand/result width; legal range 2..32.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- on  in  1  enable; 0 freezes all state and registers.
- in_sel  in  3  command, one-hot: [2] persist, [1] load, [0] reset. Any other code is treated as persist.
- num1  in  WIDTH  operand A.
- num2  in  WIDTH  operand B.
- out_sel  in  7  one-hot op: [6] add, [5] sub, [4] and, [3] or, [2] xor, [1] shl, [0] mul.
- final1  out  WIDTH  latched operand A.
- final2  out  WIDTH  latched operand B.
- out  out  WIDTH  result, low half for mul.
- out_hi  out  WIDTH  high half of the mul product; 0 for all other ops.
- carry  out  1  carry/borrow/overflow flag.
- zero  out  1  result-zero flag.
- busy  out  1  high in LOAD and MULT.
- done  out  1  one-cycle completion pulse.
- err  out  1  illegal out_sel seen.
- currState  out  2  registered FSM state.
- nextState  out  2  combinational next state.

Behaviour:
- Reset: rst=1 asynchronously forces every output register to 0 and state to IDLE. nextState follows combinationally.
- Priority each edge: rst > on=0 > reset command > load command > FSM.
- on=0: every register holds, including the MULT iteration counter. nextState = currState.
- Reset command (in_sel=001, on=1): synchronous abort from any state. Clears final1, final2, out, out_hi, carry, zero, err; next state IDLE.
- States: IDLE=00, LOAD=01, MULT=10, DONE=11.
- IDLE:
  - Load command latches num1/num2 into final1/final2 and clears err; next state LOAD.
  - Otherwise stay in IDLE.
- LOAD: samples out_sel.
  - Single-cycle op: result and flags written; next state DONE.
  - mul: accumulator and counter cleared; next state MULT.
  - Not one-hot (including 0): err=1, out/out_hi/flags unchanged; next state DONE.
- MULT:
  - One shift-add iteration per enabled cycle, WIDTH iterations total.
  - On the last iteration, {out_hi, out} = final1*final2 (unsigned, 2*WIDTH bits); next state DONE.
- DONE: done=1 for exactly this cycle; next state IDLE. Results and err persist until the next load or reset command.
- Latency from the load edge to done=1: 2 cycles for single-cycle ops, WIDTH+2 cycles for mul, with on held high.
- Load command outside IDLE is ignored; operands are not re-latched.
- Arithmetic:
  - add: {carry, out} = final1 + final2.
  - sub: out = final1 - final2 mod 2^WIDTH; carry = (final1 < final2).
  - and/or/xor: bitwise; carry = 0.
  - shl: out = final1 << final2 using the full final2 value; a shift of WIDTH or more gives 0; carry = 0.
  - mul: carry = (out_hi != 0).
- zero flag: (out == 0) for single-cycle ops; (product == 0) for mul.
- out_hi is cleared by every single-cycle op.

Test Plan:
- Add (WIDTH=8): load 0x57/0x1A, out_sel=1000000 -> out=0x71, carry=0, zero=0, done exactly 2 cycles after the load edge. Then add 0xFF+0x01 -> out=0x00, carry=1, zero=1.
- Sub: 0x02-0x04 (out_sel=0100000) -> out=0xFE, carry=1. Shl: 0x03 by 9 (out_sel=0000010) -> out=0x00, zero=1.
- Mul: 0x02*0x04 -> out=0x08, out_hi=0x00, done at the load edge +10 cycles. Then 0xFF*0xFF -> out=0x01, out_hi=0xFE, carry=1.
- Stall: hold on=0 for 3 cycles mid-MULT -> currState stays 10 and the counter freezes; done arrives 3 cycles late with the correct product. A load command issued during MULT is ignored (final1/final2 unchanged).
- Illegal op: out_sel=0000011 -> err=1, out unchanged, done pulses. The next load clears err.
- Reset: assert rst asynchronously mid-MULT -> all outputs 0 and currState=00 before the next clk edge. A reset command (in_sel=001) in DONE clears final1/final2/out on the next edge.
